// File: rtl/full_adder_pkg.sv
// ---------------------------------------------------------------------------
// full_adder_pkg
// Shared definitions for the registered ripple-carry adder.
//   MAX_WIDTH : widest operand the adder is meant to be built with.
//   ref_add   : golden {carry, sum} of a + b + cin for a given width. Operands
//               are passed zero-extended to MAX_WIDTH. Result bit `width` is
//               the carry-out and bits [width-1:0] are the sum. All higher
//               bits are zero.
// ---------------------------------------------------------------------------
package full_adder_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH:0] ref_add(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 cin,
        input int unsigned          width
    );
        logic [MAX_WIDTH:0] full;
        logic [MAX_WIDTH:0] mask;
        full = {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
        // Keep sum bits plus the carry bit. At width == MAX_WIDTH the shift
        // overflows to zero, and subtracting 1 then gives an all-ones mask.
        mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
        return full & mask;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// ---------------------------------------------------------------------------
// full_adder_cell
// Purely combinational 1-bit full adder. It is the link in the ripple chain.
//   a, b : operand bits
//   cin  : carry into this bit
//   s    : sum bit, a ^ b ^ cin
//   cout : carry out, the majority of (a, b, cin)
// ---------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Registered WIDTH-bit adder: {final_carry, final_sum} = a + b + cin.
// A ripple chain of full_adder_cell instances feeds one output register.
// The result appears one clock after it is captured.
//   clk         : rising-edge clock
//   rst         : asynchronous, active-high reset. It clears the outputs at once.
//   in_valid    : a/b/cin are captured at the edge only while this is high
//   a, b        : unsigned addends, WIDTH bits
//   cin         : carry into bit 0
//   out_valid   : high for the one cycle after a capture
//   final_sum   : registered (a + b + cin) mod 2^WIDTH
//   final_carry : registered carry-out of the MSB
// ---------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] final_sum,
    output logic             final_carry
);

    // carry_chain[gi] is the carry into bit gi. carry_chain[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_next;

    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             valid_reg;

    assign carry_chain[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry_chain[gi]),
                .s    (sum_next[gi]),
                .cout (carry_chain[gi+1])
            );
        end
    endgenerate

    // The result registers only load on a capture. They hold their value
    // through idle cycles, while out_valid tracks in_valid on every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg   <= sum_next;
                carry_reg <= carry_chain[WIDTH];
            end
        end
    end

    assign final_sum   = sum_reg;
    assign final_carry = carry_reg;
    assign out_valid   = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// ---------------------------------------------------------------------------
// tb_full_adder
// This bench drives directed vectors into a WIDTH=1 adder and a WIDTH=8
// adder. It ends with a random back-to-back run on the 8-bit adder.
// ---------------------------------------------------------------------------
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 1-bit instance
    logic       rst1 = 1'b1;
    logic       in_valid1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       out_valid1;
    logic [0:0] sum1;
    logic       carry1;

    // 8-bit instance
    logic       rst8 = 1'b1;
    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       out_valid8;
    logic [7:0] sum8;
    logic       carry8;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .final_sum(sum1), .final_carry(carry1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .final_sum(sum8), .final_carry(carry8)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Checks all three outputs of the 1-bit instance.
    task automatic check1(input string tag, input logic es, input logic ec, input logic ev);
        $display("[TB] w1 %s: sum=%0b carry=%0b valid=%0b", tag, sum1, carry1, out_valid1);
        check({tag, ".sum"},   65'(sum1),       65'(es));
        check({tag, ".carry"}, 65'(carry1),     65'(ec));
        check({tag, ".valid"}, 65'(out_valid1), 65'(ev));
    endtask

    // Checks all three outputs of the 8-bit instance.
    task automatic check8(input string tag, input logic [7:0] es, input logic ec, input logic ev);
        $display("[TB] w8 %s: sum=%02h carry=%0b valid=%0b", tag, sum8, carry8, out_valid8);
        check({tag, ".sum"},   65'(sum8),       65'(es));
        check({tag, ".carry"}, 65'(carry8),     65'(ec));
        check({tag, ".valid"}, 65'(out_valid8), 65'(ev));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed truth table, indexed by {a,b,cin}.
    logic [7:0] tt_sum   = 8'b1001_0110;
    logic [7:0] tt_carry = 8'b1110_1000;

    initial begin : stim
        logic [2:0]  v;
        logic [7:0]  exp_sum;
        logic        exp_carry;
        logic [64:0] r;
        logic        iv;

        // Reset state, checked before any clock edge
        #2;
        check1("reset0", 1'b0, 1'b0, 1'b0);
        check8("reset0", 8'h00, 1'b0, 1'b0);
        tick();
        rst1 = 1'b0;
        rst8 = 1'b0;

        // Exhaustive 1-bit, back-to-back
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1'b1;
            tick();
            check1($sformatf("tt%0d%0d%0d", v[2], v[1], v[0]), tt_sum[i], tt_carry[i], 1'b1);
        end

        // Asynchronous reset between edges after loading 111
        a1 = 1; b1 = 1; cin1 = 1; in_valid1 = 1'b1;
        tick();
        check1("load111", 1'b1, 1'b1, 1'b1);
        #2 rst1 = 1'b1;
        #1;
        check1("async_rst", 1'b0, 1'b0, 1'b0);
        a1 = 1; b1 = 0; cin1 = 0; in_valid1 = 1'b1;
        tick();
        check1("rst_held", 1'b0, 1'b0, 1'b0);
        rst1 = 1'b0;
        tick();
        check1("post_rst100", 1'b1, 1'b0, 1'b1);

        // Hold on in_valid=0
        a1 = 1; b1 = 0; cin1 = 0; in_valid1 = 1'b1;
        tick();
        check1("hold_load", 1'b1, 1'b0, 1'b1);
        a1 = 1; b1 = 1; cin1 = 1; in_valid1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b0);
        end

        // 8-bit wrap and directed vectors
        a8 = 8'hFF; b8 = 8'h01; cin8 = 0; in_valid8 = 1'b1;
        tick();
        check8("ff+01+0", 8'h00, 1'b1, 1'b1);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1;
        tick();
        check8("ff+ff+1", 8'hFF, 1'b1, 1'b1);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1;
        tick();
        check8("12+34+1", 8'h47, 1'b0, 1'b1);
        in_valid8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1;
        tick();
        check8("idle8", 8'h47, 1'b0, 1'b0);

        // Random back-to-back on the 8-bit adder
        exp_sum = 8'h47;
        exp_carry = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            iv   = 1'($urandom_range(0, 1));
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom_range(0, 1));
            in_valid8 = iv;
            if (iv) begin
                r = ref_add(64'(a8), 64'(b8), cin8, 8);
                exp_sum   = r[7:0];
                exp_carry = r[8];
            end
            tick();
            check8($sformatf("rnd%0d", i), exp_sum, exp_carry, iv);
        end
        in_valid8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
